// File: rtl/bram_rom_sequencer_if.sv
// Read-only port between the ROM sequencer and a ROM-configured GENERIC_BRAM.
// The sequencer drives the address and strobes; the BRAM returns DataOutA.
interface bram_rom_sequencer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) ();
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_weren;
    logic              rom_arst;
    logic [DATA_W-1:0] rom_data;

    modport master (
        output rom_addr,
        output rom_weren,
        output rom_arst,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        input  rom_weren,
        input  rom_arst,
        output rom_data
    );
endinterface

// File: rtl/bram_rom_sequencer.sv
// Steps a BRAM read address through [FIRST_ADDR, LAST_ADDR] at a prescaled rate,
// absorbs the BRAM read latency and holds each fetched word on data_out.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | stopped; waits for start, data_out and rom_addr hold
// S_FETCH | BRAM samples rom_addr at the closing edge
// S_WAIT  | READ_LAT cycles until DataOutA is valid, captured on the last
// S_HOLD  | sample on display; prescaler counts down while en=1
module bram_rom_sequencer #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 575,
    parameter int DIVISOR    = 8192,
    parameter int READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop,
    input  logic                  en,
    bram_rom_sequencer_if.master  rom,
    output logic [DATA_W-1:0]     data_out,
    output logic                  sample_valid,
    output logic                  wrap,
    output logic                  done,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam int PRE_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    localparam logic [ADDR_W-1:0] A_FIRST  = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] A_LAST   = ADDR_W'(LAST_ADDR);
    localparam logic [PRE_W-1:0]  PRE_LOAD = PRE_W'(DIVISOR - 1);
    localparam logic              LAT_LOAD = 1'(READ_LAT - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [PRE_W-1:0]  pre_cnt;
    logic              lat_cnt;

    assign rom.rom_addr  = addr_q;
    assign rom.rom_weren = 1'b0;
    assign rom.rom_arst  = 1'b0;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            addr_q       <= A_FIRST;
            data_out     <= '0;
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
            done         <= 1'b0;
            pre_cnt      <= '0;
            lat_cnt      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
            done         <= 1'b0;
            // stop outranks everything, including a start in the same cycle
            if (stop) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            addr_q <= A_FIRST;
                            state  <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        lat_cnt <= LAT_LOAD;
                        state   <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (lat_cnt == 1'b0) begin
                            data_out     <= rom.rom_data;
                            pre_cnt      <= PRE_LOAD;
                            sample_valid <= 1'b1;
                            state        <= S_HOLD;
                        end else begin
                            lat_cnt <= lat_cnt - 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (en) begin
                            if (pre_cnt != '0) begin
                                pre_cnt <= pre_cnt - 1'b1;
                            end else if (addr_q != A_LAST) begin
                                addr_q <= addr_q + 1'b1;
                                state  <= S_FETCH;
                            end else if (loop) begin
                                addr_q <= A_FIRST;
                                wrap   <= 1'b1;
                                state  <= S_FETCH;
                            end else begin
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
